// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - line-addressed RAM endpoint with fixed access latency and completion counters
module ram_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              not_reset,
  input  logic              ram_avalid,
  input  logic              ram_wr,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wdata,
  output logic              ram_ack,
  output logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  // The counter is loaded with LATENCY-1 so the ack lands exactly LATENCY edges after capture.
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  state_t              state_q;
  state_t              state_d;
  logic [7:0]          lat_cnt;
  logic                req_wr;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                do_capture;
  logic                do_abort;
  logic                do_done;
  logic                mem_we;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  // State register.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic and per-edge transaction events; ACK ignores ram_avalid entirely.
  always_comb begin
    state_d    = state_q;
    do_capture = 1'b0;
    do_abort   = 1'b0;
    do_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ram_avalid) begin
          do_capture = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (!ram_avalid) begin
          do_abort = 1'b1;
          state_d  = IDLE;
        end else if (lat_cnt == 8'd0) begin
          do_done = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A write commits on the ack edge, so a following read of the same line sees the new data.
  assign mem_we = do_done & req_wr;

  // Storage array; deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[req_addr] <= req_wdata;
  end

  // Request capture, latency countdown, registered outputs and saturating counters.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      lat_cnt   <= 8'd0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      ram_ack   <= 1'b0;
      busy      <= 1'b0;
      ram_rdata <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      if (do_capture) begin
        req_wr    <= ram_wr;
        req_addr  <= ram_addr;
        req_wdata <= ram_wdata;
        lat_cnt   <= LAT_LOAD;
        busy      <= 1'b1;
      end
      if (do_abort) busy <= 1'b0;
      if (state_q == WAIT && ram_avalid && lat_cnt != 8'd0) lat_cnt <= lat_cnt - 8'd1;
      if (do_done) begin
        ram_ack <= 1'b1;
        if (req_wr) begin
          if (wr_cnt != {CNT_W{1'b1}}) wr_cnt <= wr_cnt + CNT_W'(1);
        end else begin
          ram_rdata <= mem[req_addr];
          if (rd_cnt != {CNT_W{1'b1}}) rd_cnt <= rd_cnt + CNT_W'(1);
        end
      end
      if (state_q == ACK) begin
        ram_ack <= 1'b0;
        busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - scoreboard bench for ram_responder
module tb_ram_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        av0, av1, av2;
  logic        ack0, ack1, ack2;
  logic        busy0, busy1, busy2;
  logic [31:0] rdata0, rdata1, rdata2;
  logic [15:0] rdc0, wrc0, rdc1, wrc1;
  logic [1:0]  rdc2, wrc2;

  int total = 0;
  int bad = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] model [256];

  typedef struct {
    bit          rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ram_responder #(.LATENCY(4)) u0 (
    .clk(clk), .not_reset(rst_n), .ram_avalid(av0), .ram_wr(wr), .ram_addr(addr),
    .ram_wdata(wdata), .ram_ack(ack0), .ram_rdata(rdata0), .busy(busy0),
    .rd_cnt(rdc0), .wr_cnt(wrc0));

  ram_responder #(.LATENCY(1)) u1 (
    .clk(clk), .not_reset(rst_n), .ram_avalid(av1), .ram_wr(wr), .ram_addr(addr),
    .ram_wdata(wdata), .ram_ack(ack1), .ram_rdata(rdata1), .busy(busy1),
    .rd_cnt(rdc1), .wr_cnt(wrc1));

  ram_responder #(.LATENCY(2), .CNT_W(2)) u2 (
    .clk(clk), .not_reset(rst_n), .ram_avalid(av2), .ram_wr(wr), .ram_addr(addr),
    .ram_wdata(wdata), .ram_ack(ack2), .ram_rdata(rdata2), .busy(busy2),
    .rd_cnt(rdc2), .wr_cnt(wrc2));

  task automatic run0(input string name, input bit w, input logic [7:0] a,
                      input logic [31:0] d, input bit hold, input bit now);
    int   lat;
    exp_t e;
    if (!now) @(negedge clk);
    wr = w; addr = a; wdata = d; av0 = 1'b1;
    sb.push_back('{rd: !w, data: model[a]});
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++;
        if (busy0 !== 1'b1) begin bad++; $display("FAIL %s_busy: got %b want 1", name, busy0); end
      end
      if (ack0 === 1'b1) begin lat = i; break; end
    end
    total++;
    if (lat != 4) begin bad++; $display("FAIL %s_latency: got %0d want 4", name, lat); end
    if (!hold) av0 = 1'b0;
    e = sb.pop_front();
    total++;
    if (e.rd) begin
      exp_rd++;
      if (rdata0 !== e.data) begin bad++; $display("FAIL %s_rdata: got %h want %h", name, rdata0, e.data); end
      last_rdata = e.data;
    end else begin
      exp_wr++;
      model[a] = d;
      if (rdata0 !== last_rdata) begin bad++; $display("FAIL %s_rdata_hold: got %h want %h", name, rdata0, last_rdata); end
    end
    total++;
    if (rdc0 !== 16'(exp_rd)) begin bad++; $display("FAIL %s_rd_cnt: got %0d want %0d", name, rdc0, exp_rd); end
    total++;
    if (wrc0 !== 16'(exp_wr)) begin bad++; $display("FAIL %s_wr_cnt: got %0d want %0d", name, wrc0, exp_wr); end
    @(negedge clk);
    total++;
    if ({ack0, busy0} !== 2'b00) begin bad++; $display("FAIL %s_ack_end: got %b want 00", name, {ack0, busy0}); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 1'b0; addr = '0; wdata = '0; av0 = 1'b0; av1 = 1'b0; av2 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ack0, busy0, ack1, busy1, ack2, busy2} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000", {ack0, busy0, ack1, busy1, ack2, busy2});
    end
    total++;
    if ({rdata0, rdc0, wrc0, rdc2, wrc2} !== '0) begin
      bad++; $display("FAIL reset_values: got %h/%0d/%0d/%0d/%0d want zeros", rdata0, rdc0, wrc0, rdc2, wrc2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    run0("wr12", 1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 1'b0);
    run0("rd12", 1'b0, 8'h12, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int seen;
    run0("b2b_wr", 1'b1, 8'h05, 32'hA5A5A5A5, 1'b1, 1'b0);
    run0("b2b_rd", 1'b0, 8'h05, 32'h0, 1'b0, 1'b1);
    seen = 0;
    repeat (8) begin @(negedge clk); if (ack0 === 1'b1 || busy0 === 1'b1) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL b2b_no_third: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_abort();
    int seen;
    run0("ab_wr1", 1'b1, 8'h30, 32'h1, 1'b0, 1'b0);
    @(negedge clk);
    wr = 1'b1; addr = 8'h30; wdata = 32'h2; av0 = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({ack0, busy0} !== 2'b01) begin bad++; $display("FAIL ab_wait: got %b want 01", {ack0, busy0}); end
    av0 = 1'b0;
    @(negedge clk);
    total++;
    if ({ack0, busy0} !== 2'b00) begin bad++; $display("FAIL ab_drop: got %b want 00", {ack0, busy0}); end
    total++;
    if (wrc0 !== 16'(exp_wr)) begin bad++; $display("FAIL ab_wr_cnt: got %0d want %0d", wrc0, exp_wr); end
    seen = 0;
    repeat (6) begin @(negedge clk); if (ack0 === 1'b1) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL ab_no_ack: got %0d acks want 0", seen); end
    run0("ab_rd", 1'b0, 8'h30, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_latency1();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      wr = (t == 0); addr = 8'h03; wdata = 32'h12345678; av1 = 1'b1;
      @(negedge clk);
      total++;
      if ({ack1, busy1} !== 2'b01) begin bad++; $display("FAIL lat1_e0_%0d: got %b want 01", t, {ack1, busy1}); end
      @(negedge clk);
      total++;
      if ({ack1, busy1} !== 2'b11) begin bad++; $display("FAIL lat1_e1_%0d: got %b want 11", t, {ack1, busy1}); end
      av1 = 1'b0;
      if (t == 1) begin
        total++;
        if (rdata1 !== 32'h12345678) begin bad++; $display("FAIL lat1_rdata: got %h want 12345678", rdata1); end
      end
      @(negedge clk);
      total++;
      if ({ack1, busy1} !== 2'b00) begin bad++; $display("FAIL lat1_e2_%0d: got %b want 00", t, {ack1, busy1}); end
    end
  endtask

  task automatic test_reset_mid_wait();
    run0("rs_wr7", 1'b1, 8'h40, 32'h7, 1'b0, 1'b0);
    @(negedge clk);
    wr = 1'b1; addr = 8'h40; wdata = 32'h9; av0 = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL rs_busy_before: got %b want 1", busy0); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({ack0, busy0, rdc0, wrc0} !== '0) begin
      bad++; $display("FAIL rs_async: got %b/%b/%0d/%0d want zeros", ack0, busy0, rdc0, wrc0);
    end
    av0 = 1'b0; exp_rd = 0; exp_wr = 0; last_rdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    run0("rs_rd", 1'b0, 8'h40, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    int got;
    int want;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      wr = 1'b0; addr = 8'h00; av2 = 1'b1;
      got = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (ack2 === 1'b1) begin got = 1; break; end
      end
      av2 = 1'b0;
      want = (t + 1 > 3) ? 3 : t + 1;
      total++;
      if (got != 1) begin bad++; $display("FAIL sat_ack_%0d: got %0d want 1", t, got); end
      total++;
      if (rdc2 !== 2'(want)) begin bad++; $display("FAIL sat_rd_cnt_%0d: got %0d want %0d", t, rdc2, want); end
      @(negedge clk);
    end
    total++;
    if (wrc2 !== 2'd0) begin bad++; $display("FAIL sat_wr_cnt: got %0d want 0", wrc2); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_abort();
    test_latency1();
    test_reset_mid_wait();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Main-memory side of the cache-to-RAM line interface: accepts line read/write requests driven by the cache control unit (ram_avalid, ram_wr) and completes each with a one-cycle ram_ack.
- Holds a line-addressed storage array with a fixed, programmable access latency, and counts completed transactions.
- Serves as the RAM model in cache benches and as the RAM-facing endpoint in the integrated cache top.

Parameters:
ADDR_W, 8, line address width; the array holds 2^ADDR_W lines
DATA_W, 32, line data width in bits
LATENCY, 4, clock edges from request capture to ram_ack rising; legal range 1..255
CNT_W, 16, width of the completed-read and completed-write counters

Ports:
clk  input  1  system clock; all state updates on the rising edge
not_reset  input  1  asynchronous, active-low reset
ram_avalid  input  1  request valid from the initiator
ram_wr  input  1  1 = line write, 0 = line read; sampled together with ram_avalid
ram_addr  input  ADDR_W  line address
ram_wdata  input  DATA_W  write line data
ram_ack  output  1  transaction complete; one-cycle pulse
ram_rdata  output  DATA_W  read line data; valid when ram_ack=1 for a read, held until the next read completes
busy  output  1  high from request capture until ram_ack falls
rd_cnt  output  CNT_W  completed reads, saturating
wr_cnt  output  CNT_W  completed writes, saturating

Behaviour:
- Reset (not_reset=0, asynchronous):
  - state=IDLE; ram_ack=0, busy=0, ram_rdata=0, rd_cnt=0, wr_cnt=0; latency counter=0.
  - Array contents are not cleared: undefined after power-up, preserved across reset.
- All outputs are registered.
- FSM states: IDLE, WAIT, ACK.
- IDLE: at an edge with ram_avalid=1, capture ram_wr, ram_addr and ram_wdata into request registers, load counter=LATENCY-1, busy<=1, go to WAIT. No request sampled → stay in IDLE.
- WAIT:
  - Captured values are used for the whole transaction. Later changes to ram_addr, ram_wr or ram_wdata are ignored.
  - If ram_avalid=0 at an edge (abort): go to IDLE, busy<=0, no array write, no ack, counters unchanged.
  - Else if counter=0: go to ACK and set ram_ack<=1.
    - Write: array[addr] <= wdata on this same edge; wr_cnt+1.
    - Read: ram_rdata <= array[addr]; rd_cnt+1.
  - Otherwise decrement the counter.
- Latency: with capture at edge E0, ram_ack is high between edges E_LATENCY and E_LATENCY+1. For LATENCY=1, ram_ack rises on the edge after capture.
- ACK: lasts exactly one cycle. At the next edge: ram_ack<=0, busy<=0, go to IDLE. ram_avalid is ignored on this edge, even if still high.
- Back-to-back requests: the initiator may hold ram_avalid high across consecutive transactions (write-back followed by line fill). A new request is captured at the first IDLE edge, i.e. the second edge after ram_ack rises, using the values present then.
- Read-after-write to the same address returns the newly written data, because the write commits on the ack edge.
- Counters saturate at 2^CNT_W-1 and never wrap.
- ram_rdata changes only on completion of a read; writes and aborts leave it unchanged.
- Reset asserted in WAIT or ACK: immediately IDLE with all outputs at reset values. A pending write is discarded.

Test Plan:
- Write addr 0x12 data 0xDEADBEEF, then read 0x12, LATENCY=4 → each ram_ack rises exactly 4 edges after capture and lasts one cycle; read ram_rdata=0xDEADBEEF; wr_cnt=1, rd_cnt=1.
- Hold ram_avalid=1 continuously: write 0x05 data 0xA5A5A5A5, then, on the cycle after ack, drive ram_wr=0 (read 0x05) → second request captured 2 edges after first ack rise; second ack returns 0xA5A5A5A5; no third transaction while ram_avalid remains low afterwards.
- Write 0x30 data 0x1, then write 0x30 data 0x2 but drop ram_avalid after 2 cycles of WAIT → no ack for the second write, busy falls, wr_cnt=1; a subsequent read of 0x30 returns 0x1.
- LATENCY=1: read request → ram_ack high on the cycle immediately after the capture edge; busy high for exactly 2 cycles.
- Assert not_reset=0 mid-WAIT of a write to 0x40 (prior data 0x7) → ram_ack, busy and counters go 0 asynchronously; a later read of 0x40 returns 0x7.
- CNT_W=2: six reads → rd_cnt sequence 1,2,3,3,3,3 (saturates, no wrap).
